async_fifo_read_stream: RTL

- Read-domain consumer for async_fifo.
- Drains the FIFO read port (p_read_en / p_read_data / p_read_empty) and re-presents the words as a valid/ready stream.
- Includes a 3-entry prefetch buffer, so downstream back-pressure never combinationally reaches the FIFO read enable, and throughput stays at 1 word/cycle.
- Sits in the read_clk domain, directly after async_fifo, and is the counterpart of the write-side producer logic.

---
 rtl/async_fifo_read_stream.sv | 72 +++++++
 1 files changed

// File: rtl/async_fifo_read_stream.sv
// Read-domain consumer for async_fifo: drains the FIFO read port into a
// 3-entry prefetch buffer and re-presents the words as a valid/ready stream.
module async_fifo_read_stream #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 32
) (
  input  logic                read_clk,
  input  logic                read_rst_n,
  output logic                p_fifo_read_en,
  input  logic [BITS-1:0]     p_fifo_read_data,
  input  logic                p_fifo_read_empty,
  output logic                p_out_valid,
  output logic [BITS-1:0]     p_out_data,
  input  logic                p_out_ready,
  output logic [1:0]          p_level,
  output logic [CNT_BITS-1:0] p_out_count
);

  logic [BITS-1:0] buf_q [3];
  logic [1:0]      occ;
  logic [1:0]      rd_ptr;
  logic [1:0]      wr_ptr;
  logic            inflight;
  logic            live;
  logic            pop;
  logic [2:0]      pending;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign pending     = {1'b0, occ} + {2'b00, inflight};
  assign p_out_valid = (occ != 2'd0);
  assign pop         = p_out_valid && p_out_ready;
  assign p_out_data  = buf_q[rd_ptr];
  assign p_level     = occ;

  // live keeps read_en low through the reset window, so it never
  // depends on the FIFO's empty flag while both are still clearing
  assign p_fifo_read_en = live && !p_fifo_read_empty
                          && (pending < 3'd3);

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      live        <= 1'b0;
      inflight    <= 1'b0;
      occ         <= 2'd0;
      rd_ptr      <= 2'd0;
      wr_ptr      <= 2'd0;
      p_out_count <= '0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      live     <= 1'b1;
      inflight <= p_fifo_read_en;
      if (inflight) begin
        buf_q[wr_ptr] <= p_fifo_read_data;
        wr_ptr        <= inc3(wr_ptr);
      end
      if (pop) begin
        rd_ptr      <= inc3(rd_ptr);
        p_out_count <= p_out_count + 1'b1;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // a capture into a full buffer with no pop would overflow occ
  always @(posedge read_clk) begin
    if (read_rst_n) assert (!(inflight && !pop && occ == 2'd3));
  end

endmodule
